// File: rtl/pre_track_cache.sv
// pre_track_cache: circular word buffer between the current-track writer and
// the second-track pre-laser aligner. Reads have a fixed two-cycle latency
// (registered RAM read, then output register). A read of an empty cache still
// produces a zero-data strobe so the aligner's timing stays fixed.
module pre_track_cache #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  laser_start_i,
  input  logic                  second_track_en_i,
  input  logic                  wr_vld_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_seq_i,
  output logic                  rd_ready_o,
  output logic                  rd_vld_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic                  rd_req;
  logic                  empty;
  logic                  full;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  s1_vld;
  logic                  s1_under;

  // Empty/full are judged on the level before this cycle's accesses, so a
  // write never fills a slot freed by a same-cycle read, and a read never
  // consumes a same-cycle write.
  assign rd_req = rd_seq_i & second_track_en_i;
  assign empty  = (level_o == '0);
  assign full   = (level_o == LVL_FULL);
  assign rd_acc = rd_req & ~empty;
  assign wr_acc = wr_vld_i & laser_start_i & ~full;

  // Next word count from this cycle's accepted write/read.
  always_comb begin
    level_nxt = level_o;
    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level_o + 1'b1;
      2'b01:   level_nxt = level_o - 1'b1;
      default: level_nxt = level_o;
    endcase
  end

  // Storage array with registered read port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wptr] <= wr_data_i;
    ram_q <= mem[rptr];
  end

  // Pointers, level, ready and sticky flags; a low laser_start_i flushes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr        <= '0;
      rptr        <= '0;
      level_o     <= '0;
      rd_ready_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (!laser_start_i) begin
      wptr        <= '0;
      rptr        <= '0;
      level_o     <= '0;
      rd_ready_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      level_o    <= level_nxt;
      rd_ready_o <= (level_nxt != '0);
      if (wr_vld_i && full) overflow_o  <= 1'b1;
      if (rd_req && empty)  underflow_o <= 1'b1;
    end
  end

  // Two-stage read pipeline; it is not flushed so in-flight reads complete.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld    <= 1'b0;
      s1_under  <= 1'b0;
      rd_vld_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      s1_vld   <= rd_req;
      s1_under <= rd_req & empty;
      rd_vld_o <= s1_vld;
      if (s1_vld) rd_data_o <= s1_under ? '0 : ram_q;
    end
  end

endmodule

// File: tb/tb_pre_track_cache.sv
// Bench for pre_track_cache (ADDR_WIDTH=4): queue-based reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_pre_track_cache;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          laser, en, wv, rs;
  logic [DW-1:0] wd;
  logic          rd_ready_o, rd_vld_o, overflow_o, underflow_o;
  logic [DW-1:0] rd_data_o;
  logic [AW:0]   level_o;

  pre_track_cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .laser_start_i(laser),
    .second_track_en_i(en), .wr_vld_i(wv), .wr_data_i(wd), .rd_seq_i(rs),
    .rd_ready_o(rd_ready_o), .rd_vld_o(rd_vld_o), .rd_data_o(rd_data_o),
    .level_o(level_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, pending reads with due cycle.
  typedef struct { int due; logic [DW-1:0] d; } pend_t;
  logic [DW-1:0] q[$];
  pend_t         pend[$];
  logic [DW-1:0] log_q[$];
  int            cyc   = 0;
  bit            m_ovf = 0;
  bit            m_unf = 0;
  bit            exp_v = 0;
  logic [DW-1:0] exp_d = '0;
  int unsigned   sz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); pend.delete();
      m_ovf = 0; m_unf = 0; exp_d = '0;
    end else begin
      cyc++;
      sz = q.size();
      if (rs && en) begin
        if (sz == 0) begin
          pend.push_back('{cyc + 1, '0});
          if (laser) m_unf = 1;
        end else pend.push_back('{cyc + 1, q[0]});
      end
      if (!laser) begin
        q.delete(); m_ovf = 0; m_unf = 0;
      end else begin
        if (rs && en && sz != 0) void'(q.pop_front());
        if (wv) begin
          if (sz < DEPTH) q.push_back(wd);
          else m_ovf = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model; strobed data is logged.
  always @(negedge clk) begin
    exp_v = 0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      exp_v = 1;
      exp_d = pend[0].d;
      void'(pend.pop_front());
    end
    chk("level", DW'(level_o), DW'(q.size()));
    chk("rd_ready", DW'(rd_ready_o), DW'(q.size() != 0));
    chk("overflow", DW'(overflow_o), DW'(m_ovf));
    chk("underflow", DW'(underflow_o), DW'(m_unf));
    chk("rd_vld", DW'(rd_vld_o), DW'(exp_v));
    chk("rd_data", rd_data_o, exp_d);
    if (rd_vld_o === 1'b1) log_q.push_back(rd_data_o);
  end

  task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
    wv = v; wd = d; rs = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0);
  endtask

  task automatic flush();
    laser = 1'b0;
    step(0, '0, 0);
    laser = 1'b1;
  endtask

  task automatic chk_log(input string nm, input int base, input int n);
    chk({nm, "_count"}, DW'(log_q.size()), DW'(n));
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk(nm, log_q[i], DW'(base + i));
  endtask

  int n0;

  initial begin
    rst_n = 1'b0; laser = 1'b0; en = 1'b0; wv = 1'b0; wd = '0; rs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", DW'(level_o), '0);
    chk("rst_rd_vld", DW'(rd_vld_o), '0);
    chk("rst_rd_data", rd_data_o, '0);
    chk("rst_flags", DW'({overflow_o, underflow_o, rd_ready_o}), '0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    laser = 1'b1;

    // Basic write then read
    for (int i = 1; i <= 5; i++) step(1, DW'(i), 0);
    en = 1'b1;
    log_q.delete();
    repeat (5) step(0, '0, 1);
    idle(3);
    chk_log("t1_data", 1, 5);
    chk("t1_level", DW'(level_o), '0);
    chk("t1_ready", DW'(rd_ready_o), '0);

    // Overflow: 17th write dropped
    flush();
    log_q.delete();
    for (int i = 1; i <= 17; i++) step(1, DW'(i), 0);
    idle(1);
    chk("t2_level_full", DW'(level_o), 64'd16);
    chk("t2_overflow", DW'(overflow_o), 64'd1);
    repeat (16) step(0, '0, 1);
    idle(3);
    chk_log("t2_data", 1, 16);
    chk("t2_underflow", DW'(underflow_o), '0);

    // Underflow read, then same-cycle read+write at level 0
    flush();
    log_q.delete();
    step(0, '0, 1);
    idle(3);
    chk("t3_count", DW'(log_q.size()), 64'd1);
    if (log_q.size() > 0) chk("t3_zero_data", log_q[0], '0);
    chk("t3_underflow", DW'(underflow_o), 64'd1);
    chk("t3_level", DW'(level_o), '0);
    step(1, 64'h77, 1);
    idle(3);
    chk("t3_rw_level", DW'(level_o), 64'd1);
    step(0, '0, 1);
    idle(3);
    chk("t3_count2", DW'(log_q.size()), 64'd3);
    if (log_q.size() > 2) chk("t3_rw_data", log_q[2], 64'h77);

    // Wrap-around with reads lagging writes by 3
    flush();
    log_q.delete();
    for (int i = 0; i < 43; i++) begin
      step(i < 40, DW'(100 + i), i >= 3);
      if (i == 20) chk("t4_level_overlap", DW'(level_o), 64'd3);
    end
    idle(3);
    chk_log("t4_data", 100, 40);

    // Flush mid-operation clears level and flags
    flush();
    step(0, '0, 1);
    idle(2);
    chk("t5_underflow_set", DW'(underflow_o), 64'd1);
    for (int i = 0; i < 7; i++) step(1, DW'(200 + i), 0);
    chk("t5_level7", DW'(level_o), 64'd7);
    flush();
    chk("t5_flush_level", DW'(level_o), '0);
    chk("t5_flush_flags", DW'({overflow_o, underflow_o, rd_ready_o}), '0);

    // Reset with reads in flight
    for (int i = 0; i < 4; i++) step(1, DW'(300 + i), 0);
    step(0, '0, 1);
    step(0, '0, 1);
    rs = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", DW'(rd_vld_o), '0);
    chk("t5_rst_data", rd_data_o, '0);
    chk("t5_rst_level", DW'(level_o), '0);
    n0 = log_q.size();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(4);
    chk("t5_no_pulse_after_rst", DW'(log_q.size()), DW'(n0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
